// File: rtl/reg_read_unit.sv
// reg_read_unit: 16-entry register file with two registered read ports.
// Writes use a one-hot wordline. Reads use a one-hot select followed by an
// AND-OR mux with no priority chain, and are captured one cycle after RdEn.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read and a
// write to the same register in the same cycle return the new data. When it
// is undefined, such a read returns the old data.
module reg_read_unit #(
  parameter int WIDTH   = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WriteReg,
  input  logic [3:0]       DstReg,
  input  logic [WIDTH-1:0] DstData,
  input  logic             RdEn,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  output logic [WIDTH-1:0] SrcData1,
  output logic [WIDTH-1:0] SrcData2,
  output logic             RdValid
);

  // R0 is masked out of both the wordline and the read selects when it is
  // hardwired to zero. The mask also keeps R0 out of the bypass path.
  localparam logic [15:0] ID_MASK = (ZERO_R0 != 0) ? 16'hFFFE : 16'hFFFF;

  logic [15:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0]       src_data1_q, src_data1_d;
  logic [WIDTH-1:0]       src_data2_q, src_data2_d;
  logic                   rd_valid_q, rd_valid_d;

  logic [15:0]            wr_sel, rd_sel1, rd_sel2;
  logic [WIDTH-1:0]       rd_data1, rd_data2;
  logic [WIDTH-1:0]       cap_data1, cap_data2;

  // One-hot decode of the write wordline and the two read selects.
  always_comb begin
    wr_sel  = (WriteReg ? (16'd1 << DstReg) : 16'd0) & ID_MASK;
    rd_sel1 = (16'd1 << SrcReg1) & ID_MASK;
    rd_sel2 = (16'd1 << SrcReg2) & ID_MASK;
  end

  // AND-OR read mux: each bit of the one-hot select gates one register.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    for (int i = 0; i < 16; i++) begin
      rd_data1 = rd_data1 | ({WIDTH{rd_sel1[i]}} & regs_q[i]);
      rd_data2 = rd_data2 | ({WIDTH{rd_sel2[i]}} & regs_q[i]);
    end
  end

  // Choose the value to capture on each port, with same-cycle forwarding
  // when bypass is built in.
  always_comb begin
    cap_data1 = rd_data1;
    cap_data2 = rd_data2;
`ifdef REGFILE_BYPASS_EN
    if ((wr_sel & rd_sel1) != 16'd0) cap_data1 = DstData;
    if ((wr_sel & rd_sel2) != 16'd0) cap_data2 = DstData;
`endif
  end

  // Next state: wordline-driven register update, read capture and valid.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 16; i++) begin
      if (wr_sel[i]) regs_d[i] = DstData;
    end
    src_data1_d = RdEn ? cap_data1 : src_data1_q;
    src_data2_d = RdEn ? cap_data2 : src_data2_q;
    rd_valid_d  = RdEn;
  end

  // State registers. Reset takes priority over any read or write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '0;
      src_data1_q <= '0;
      src_data2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      src_data1_q <= src_data1_d;
      src_data2_q <= src_data2_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign SrcData1 = src_data1_q;
  assign SrcData2 = src_data2_q;
  assign RdValid  = rd_valid_q;

endmodule

// File: tb/tb_reg_read_unit.sv
// Testbench for reg_read_unit. It runs two instances side by side, one with
// ZERO_R0=0 and one with ZERO_R0=1. An array model of the register contents
// is checked against both instances on every cycle after reset, and directed
// literal checks pin the model.
module tb_reg_read_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [3:0]  dst = '0;
  logic [15:0] ddat = '0;
  logic        rde = 1'b0;
  logic [3:0]  s1 = '0, s2 = '0;
  logic [15:0] d1 [2];
  logic [15:0] d2 [2];
  logic        vld [2];

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit started = 1'b0;

  logic [15:0] mem  [2][16];
  logic [15:0] exp1 [2];
  logic [15:0] exp2 [2];
  logic        exp_v;

  always #5 clk = ~clk;

  reg_read_unit #(.WIDTH(16), .ZERO_R0(0)) u0 (
    .clk(clk), .rst(rst), .WriteReg(we), .DstReg(dst), .DstData(ddat),
    .RdEn(rde), .SrcReg1(s1), .SrcReg2(s2),
    .SrcData1(d1[0]), .SrcData2(d2[0]), .RdValid(vld[0])
  );

  reg_read_unit #(.WIDTH(16), .ZERO_R0(1)) u1 (
    .clk(clk), .rst(rst), .WriteReg(we), .DstReg(dst), .DstData(ddat),
    .RdEn(rde), .SrcReg1(s1), .SrcReg2(s2),
    .SrcData1(d1[1]), .SrcData2(d2[1]), .RdValid(vld[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value a read of register id returns in instance k, given this cycle's write.
  function automatic logic [15:0] model_read(input int k, input logic [3:0] id);
    if (k == 1 && id == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (we && dst == id) return ddat;
`endif
    return mem[k][id];
  endfunction

  // Reference model: the reads use the register contents from before this
  // edge's write.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 16; r++) mem[k][r] = 16'h0000;
        exp1[k] = 16'h0000;
        exp2[k] = 16'h0000;
      end
      exp_v = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rde) begin
          exp1[k] = model_read(k, s1);
          exp2[k] = model_read(k, s2);
        end
        if (we && !(k == 1 && dst == 4'd0)) mem[k][dst] = ddat;
      end
      exp_v = rde;
    end
  end

  // Compare the outputs of both instances against the model at every falling edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rdvalid_u%0d", k), {31'd0, vld[k]}, {31'd0, exp_v});
        chk($sformatf("model_src1_u%0d", k), {16'd0, d1[k]}, {16'd0, exp1[k]});
        chk($sformatf("model_src2_u%0d", k), {16'd0, d2[k]}, {16'd0, exp2[k]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then read R3 and R15.
    rst = 1'b1;
    cyc(); cyc();
    started = 1'b1;
    rst = 1'b0;
    chk("reset_rdvalid", {31'd0, vld[0]}, 32'd0);
    chk("reset_src1", {16'd0, d1[0]}, 32'd0);
    rde = 1'b1; s1 = 4'd3; s2 = 4'd15;
    cyc();
    rde = 1'b0;
    chk("rst_read_valid", {31'd0, vld[0]}, 32'd1);
    chk("rst_read_src1", {16'd0, d1[0]}, 32'h0000);
    chk("rst_read_src2", {16'd0, d2[0]}, 32'h0000);

    // Write R(i) = 0x1000 + i for all registers.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; dst = 4'(i); ddat = 16'(16'h1000 + i);
      cyc();
    end
    we = 1'b0;

    // Read the pairs (i, 15 - i).
    for (int i = 0; i < 16; i++) begin
      rde = 1'b1; s1 = 4'(i); s2 = 4'(15 - i);
      cyc();
      chk($sformatf("pair%0d_src1", i), {16'd0, d1[0]}, 32'h1000 + 32'(i));
      chk($sformatf("pair%0d_src2", i), {16'd0, d2[0]}, 32'h100F - 32'(i));
      chk($sformatf("pair%0d_z_src1", i), {16'd0, d1[1]}, (i == 0) ? 32'd0 : 32'h1000 + 32'(i));
      chk($sformatf("pair%0d_z_src2", i), {16'd0, d2[1]}, (i == 15) ? 32'd0 : 32'h100F - 32'(i));
    end
    rde = 1'b0;

    // A write attempt with WriteReg=0 must not change R5.
    we = 1'b0; dst = 4'd5; ddat = 16'hBEEF;
    cyc();
    rde = 1'b1; s1 = 4'd5; s2 = 4'd6;
    cyc();
    rde = 1'b0;
    chk("we0_guard_r5", {16'd0, d1[0]}, 32'h1005);

    // Write and read R7 in the same cycle.
    we = 1'b1; dst = 4'd7; ddat = 16'h1234;
    cyc();
    ddat = 16'hABCD; rde = 1'b1; s1 = 4'd7; s2 = 4'd3;
    cyc();
    we = 1'b0;
`ifdef REGFILE_BYPASS_EN
    chk("hazard_src1", {16'd0, d1[0]}, 32'hABCD);
`else
    chk("hazard_src1", {16'd0, d1[0]}, 32'h1234);
`endif
    chk("hazard_src2", {16'd0, d2[0]}, 32'h1003);
    cyc();
    rde = 1'b0;
    chk("hazard_after", {16'd0, d1[0]}, 32'hABCD);

    // RdEn pattern 1,1,0,1: outputs hold during the gap and RdValid drops for one cycle.
    rde = 1'b1; s1 = 4'd1; s2 = 4'd2; cyc();
    s1 = 4'd2; s2 = 4'd9; cyc();
    chk("hold_v2", {31'd0, vld[0]}, 32'd1);
    rde = 1'b0; s1 = 4'd11; s2 = 4'd12; cyc();
    chk("hold_gap_v", {31'd0, vld[0]}, 32'd0);
    chk("hold_gap_src1", {16'd0, d1[0]}, 32'h1002);
    chk("hold_gap_src2", {16'd0, d2[0]}, 32'h1009);
    rde = 1'b1; s1 = 4'd4; s2 = 4'd5; cyc();
    rde = 1'b0;
    chk("hold_v4", {31'd0, vld[0]}, 32'd1);
    chk("hold_v4_src1", {16'd0, d1[0]}, 32'h1004);

    // Write and read R0: only the ZERO_R0=1 instance forces zero.
    we = 1'b1; dst = 4'd0; ddat = 16'hFFFF; rde = 1'b1; s1 = 4'd0; s2 = 4'd0;
    cyc();
    we = 1'b0;
    chk("zero_r0_same", {16'd0, d1[1]}, 32'h0000);
    cyc();
    rde = 1'b0;
    chk("zero_r0_later", {16'd0, d2[1]}, 32'h0000);
    chk("plain_r0_later", {16'd0, d1[0]}, 32'hFFFF);

    // Reset in the same cycle as a read and a write to R4.
    rst = 1'b1; rde = 1'b1; we = 1'b1; dst = 4'd4; ddat = 16'h5555; s1 = 4'd4;
    cyc();
    rst = 1'b0; we = 1'b0;
    chk("midrst_valid", {31'd0, vld[0]}, 32'd0);
    chk("midrst_src1", {16'd0, d1[0]}, 32'd0);
    rde = 1'b1; s1 = 4'd4; s2 = 4'd4;
    cyc();
    rde = 1'b0;
    chk("midrst_r4", {16'd0, d1[0]}, 32'h0000);

    // Random traffic, checked by the model on every cycle.
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      we   = ($urandom_range(0, 1) == 1);
      dst  = 4'($urandom_range(0, 15));
      ddat = 16'($urandom);
      rde  = ($urandom_range(0, 2) != 0);
      s1   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      s2   = ($urandom_range(0, 3) == 0) ? s1  : 4'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b0; we = 1'b0; rde = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
